// File: rtl/parking_pkg.sv
// Shared encodings and constants for the ultrasonic parking-distance ranger.
package parking_pkg;

   typedef enum logic [2:0] {IDLE, TRIG, WAIT, MEAS, DONE, TOUT, HOLD} state_t;

   localparam int         US_PER_CM = 58;
   localparam logic [3:0] LEVEL_MAX = 4'd7;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running microsecond strobe: one-cycle tick every CLK_HZ/1e6 clocks.
module us_tick_gen
   import parking_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            DIV  = CLK_HZ / 1_000_000;
   localparam int            CW   = cw(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/ultrasonic_distance_level.sv
// HC-SR04 style ranger: periodic trigger, echo width timing, and 0..7 distance zone output.
module ultrasonic_distance_level
   import parking_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TRIG_US    = 10,
   parameter int PERIOD_US  = 60000,
   parameter int TIMEOUT_US = 30000,
   parameter int ZONE_CM    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       echo,
   output logic       trig,
   output logic [3:0] level,
   output logic       valid,
   output logic       no_echo
);

   localparam int US_W  = cw(PERIOD_US);
   localparam int MT_W  = cw(TIMEOUT_US);
   localparam int SUB_W = cw(US_PER_CM);
   localparam int MOD_W = cw(ZONE_CM);
   localparam int CM_W  = cw(TIMEOUT_US / US_PER_CM + 1);

   localparam logic [US_W-1:0]  TRIG_LAST   = US_W'(TRIG_US - 1);
   localparam logic [US_W-1:0]  WAIT_LAST   = US_W'(TIMEOUT_US - 1);
   localparam logic [US_W-1:0]  PERIOD_LAST = US_W'(PERIOD_US - 1);
   localparam logic [MT_W-1:0]  MEAS_LAST   = MT_W'(TIMEOUT_US - 1);
   localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(US_PER_CM - 1);
   localparam logic [MOD_W-1:0] MOD_LAST    = MOD_W'(ZONE_CM - 1);
   localparam logic [2:0]       ZONE_MAX    = LEVEL_MAX[2:0];

   state_t           state;
   logic             tick;
   logic             echo_m, echo_s, echo_q;
   logic             rise, fall;
   logic [US_W-1:0]  us_cnt;
   logic [MT_W-1:0]  meas_cnt;
   logic [SUB_W-1:0] cm_sub;
   logic [MOD_W-1:0] cm_mod;
   logic [CM_W-1:0]  cm;
   logic [2:0]       zone, zone_nxt;
   logic             sub_wrap, mod_wrap;

   us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         {echo_q, echo_s, echo_m} <= 3'b000;
      else
         {echo_q, echo_s, echo_m} <= {echo_s, echo_m, echo};
   end

   assign rise = echo_s & ~echo_q;
   assign fall = ~echo_s & echo_q;

   // Zone including the current tick, so a fall on a wrap tick still counts that centimetre.
   assign sub_wrap = tick && (cm_sub == SUB_LAST);
   assign mod_wrap = sub_wrap && (cm_mod == MOD_LAST);
   assign zone_nxt = (mod_wrap && (zone != ZONE_MAX)) ? zone + 3'd1 : zone;

   // valid is a one-cycle strobe with no back-pressure; level and no_echo hold until the next strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         trig     <= 1'b0;
         level    <= LEVEL_MAX;
         valid    <= 1'b0;
         no_echo  <= 1'b0;
         us_cnt   <= '0;
         meas_cnt <= '0;
         cm_sub   <= '0;
         cm_mod   <= '0;
         cm       <= '0;
         zone     <= '0;
      end else begin
         valid <= 1'b0;
         if (tick && (state != IDLE) && (us_cnt != PERIOD_LAST))
            us_cnt <= us_cnt + US_W'(1);
         case (state)
            IDLE: begin
               if (en) begin
                  state  <= TRIG;
                  trig   <= 1'b1;
                  us_cnt <= '0;
               end
            end
            TRIG: begin
               if (tick && (us_cnt == TRIG_LAST)) begin
                  state <= WAIT;
                  trig  <= 1'b0;
               end
            end
            WAIT: begin
               if (rise) begin
                  state    <= MEAS;
                  meas_cnt <= '0;
                  cm_sub   <= '0;
                  cm_mod   <= '0;
                  cm       <= '0;
                  zone     <= '0;
               end else if (tick && (us_cnt == WAIT_LAST)) begin
                  state   <= TOUT;
                  level   <= LEVEL_MAX;
                  no_echo <= 1'b1;
                  valid   <= 1'b1;
               end
            end
            MEAS: begin
               zone <= zone_nxt;
               if (tick) begin
                  meas_cnt <= meas_cnt + MT_W'(1);
                  if (sub_wrap) begin
                     cm_sub <= '0;
                     cm     <= cm + CM_W'(1);
                     cm_mod <= mod_wrap ? '0 : cm_mod + MOD_W'(1);
                  end else begin
                     cm_sub <= cm_sub + SUB_W'(1);
                  end
               end
               if (fall) begin
                  state   <= DONE;
                  level   <= {1'b0, zone_nxt};
                  no_echo <= 1'b0;
                  valid   <= 1'b1;
               end else if (tick && (meas_cnt == MEAS_LAST)) begin
                  state   <= TOUT;
                  level   <= LEVEL_MAX;
                  no_echo <= 1'b1;
                  valid   <= 1'b1;
               end
            end
            DONE, TOUT: state <= HOLD;
            HOLD: begin
               if (tick && (us_cnt == PERIOD_LAST)) begin
                  if (en) begin
                     state  <= TRIG;
                     trig   <= 1'b1;
                     us_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
